// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of committed stores between memory-stage issue
// and data-memory write port 1. Drains the oldest entry whenever the port is
// not claimed by a load, forwards exact-match store data to loads and stalls
// loads that only partially overlap a buffered store.
// Optional build macro: STORE_MERGE_EN (a store identical in addr/funct3 to
// the youngest entry overwrites that entry's data instead of allocating).
module store_buffer #(
  parameter int XLEN          = 32,
  parameter int ADDRESS_WIDTH = 17,
  parameter int DEPTH         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  input  logic [2:0]      st_funct3,
  input  logic            mem_busy,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  output logic [2:0]      mem_funct3,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [2:0]      ld_funct3,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data,
  output logic            ld_stall,
  output logic            sb_empty
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]   ent_addr [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [2:0]      ent_f3   [DEPTH];

  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic            st_f3_ok;
  logic            do_alloc;
  logic            do_merge;

  logic [2:0]      ld_size;
  logic            hit_found;
  logic [PW-1:0]   hit_idx;
  logic [PW-1:0]   lk_idx;
  logic [XLEN-1:0] hit_data;

  logic            unused_addr_hi;

  // Bytes written by a store type; 0 marks an unsupported encoding.
  function automatic logic [2:0] store_size(input logic [2:0] f3);
    case (f3)
      3'b000:  store_size = 3'd1;
      3'b001:  store_size = 3'd2;
      3'b010:  store_size = 3'd4;
      default: store_size = 3'd0;
    endcase
  endfunction

  // Bytes read by a load type; 0 marks an unsupported encoding.
  function automatic logic [2:0] load_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: load_size = 3'd1;
      3'b001, 3'b101: load_size = 3'd2;
      3'b010:         load_size = 3'd4;
      default:        load_size = 3'd0;
    endcase
  endfunction

  // Byte-set intersection; sums are truncated to AW bits so accesses that
  // run off the top of memory wrap to address 0 just like the memory does.
  function automatic logic bytes_overlap(input logic [AW-1:0] sa, input logic [2:0] ssz,
                                         input logic [AW-1:0] la, input logic [2:0] lsz);
    logic [AW-1:0] sb;
    logic [AW-1:0] lb;
    bytes_overlap = 1'b0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        sb = sa + AW'(j);
        lb = la + AW'(k);
        if ((3'(j) < ssz) && (3'(k) < lsz) && (sb == lb)) bytes_overlap = 1'b1;
      end
    end
  endfunction

  // Only the low AW address bits reach memory; the upper bits are ignored.
  assign unused_addr_hi = ^{st_addr[XLEN-1:AW], ld_addr[XLEN-1:AW]};

  assign sb_empty   = (count == '0);
  assign st_ready   = (count < CW'(DEPTH));
  assign mem_we     = !sb_empty && !mem_busy && rst_n;
  assign mem_addr   = sb_empty ? '0 : {{(XLEN-AW){1'b0}}, ent_addr[head]};
  assign mem_wd     = sb_empty ? '0 : ent_data[head];
  assign mem_funct3 = sb_empty ? '0 : ent_f3[head];

`ifdef STORE_MERGE_EN
  logic [PW-1:0] young;
  assign young = tail - PW'(1);
`endif

  // Decide whether an accepted store allocates a new slot or merges into the youngest one.
  always_comb begin
    st_f3_ok = (st_funct3 == 3'b000) || (st_funct3 == 3'b001) || (st_funct3 == 3'b010);
    do_merge = 1'b0;
`ifdef STORE_MERGE_EN
    do_merge = st_valid && st_ready && st_f3_ok && !sb_empty &&
               (ent_addr[young] == st_addr[AW-1:0]) && (ent_f3[young] == st_funct3) &&
               !((count == CW'(1)) && mem_we);
`endif
    do_alloc = st_valid && st_ready && st_f3_ok && !do_merge;
  end

  // Scan oldest to youngest so the last overlapping entry found is the youngest.
  always_comb begin
    ld_size   = load_size(ld_funct3);
    hit_found = 1'b0;
    hit_idx   = '0;
    lk_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head + PW'(i);
      if ((CW'(i) < count) &&
          bytes_overlap(ent_addr[lk_idx], store_size(ent_f3[lk_idx]), ld_addr[AW-1:0], ld_size)) begin
        hit_found = 1'b1;
        hit_idx   = lk_idx;
      end
    end
  end

  // Forward on an exact address/size match, otherwise stall an overlapping load.
  always_comb begin
    fwd_hit  = 1'b0;
    ld_stall = 1'b0;
    fwd_data = '0;
    hit_data = ent_data[hit_idx];
    if (ld_valid && (ld_size != 3'd0) && hit_found) begin
      if ((ent_addr[hit_idx] == ld_addr[AW-1:0]) && (store_size(ent_f3[hit_idx]) == ld_size)) begin
        fwd_hit = 1'b1;
        case (ld_funct3)
          3'b000:  fwd_data = {{(XLEN-8){hit_data[7]}}, hit_data[7:0]};
          3'b001:  fwd_data = {{(XLEN-16){hit_data[15]}}, hit_data[15:0]};
          3'b100:  fwd_data = {{(XLEN-8){1'b0}}, hit_data[7:0]};
          3'b101:  fwd_data = {{(XLEN-16){1'b0}}, hit_data[15:0]};
          default: fwd_data = hit_data;
        endcase
      end else begin
        ld_stall = 1'b1;
      end
    end
  end

  // Pointer, occupancy and entry storage updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_f3[i]   <= '0;
      end
    end else begin
      if (do_alloc) begin
        ent_addr[tail] <= st_addr[AW-1:0];
        ent_data[tail] <= st_data;
        ent_f3[tail]   <= st_funct3;
        tail           <= tail + PW'(1);
      end
      if (do_merge) begin
        ent_data[tail - PW'(1)] <= st_data;
      end
      if (mem_we) begin
        head <= head + PW'(1);
      end
      case ({do_alloc, mem_we})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scenario-per-task bench for store_buffer with a drain
// scoreboard. Stores push their expected drain record when accepted; a
// monitor pops and compares whenever a memory write is about to happen.
`timescale 1ns/1ps
module tb_store_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            st_valid = 1'b0;
  logic            st_ready;
  logic [XLEN-1:0] st_addr = '0;
  logic [XLEN-1:0] st_data = '0;
  logic [2:0]      st_funct3 = '0;
  logic            mem_busy = 1'b0;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wd;
  logic [2:0]      mem_funct3;
  logic            ld_valid = 1'b0;
  logic [XLEN-1:0] ld_addr = '0;
  logic [2:0]      ld_funct3 = '0;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
  logic            ld_stall;
  logic            sb_empty;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } entry_t;

  entry_t sbq[$];
  entry_t mon_e;
  int total = 0;
  int bad   = 0;

  store_buffer #(.XLEN(32), .ADDRESS_WIDTH(17), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_funct3(mem_funct3),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_stall(ld_stall), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  // Drain monitor: a write pending for the next edge must match the oldest expected store.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && mem_we) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("[TB] FAIL drain_unexpected: got write addr=%h wd=%h, want no write", mem_addr, mem_wd);
      end else begin
        mon_e = sbq.pop_front();
        if (mem_addr !== mon_e.addr || mem_wd !== mon_e.data || mem_funct3 !== mon_e.f3) begin
          bad++;
          $display("[TB] FAIL drain_order: got addr=%h wd=%h f3=%b, want addr=%h wd=%h f3=%b",
                   mem_addr, mem_wd, mem_funct3, mon_e.addr, mon_e.data, mon_e.f3);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    logic   exp_ready;
    logic   merge;
    entry_t e;
    @(negedge clk);
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
    #1;
    exp_ready = (sbq.size() < DEPTH);
    total++;
    if (st_ready !== exp_ready) begin
      bad++;
      $display("[TB] FAIL st_ready: got %b, want %b", st_ready, exp_ready);
    end
    if (exp_ready && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)) begin
      merge = 1'b0;
`ifdef STORE_MERGE_EN
      if (sbq.size() != 0 && sbq[sbq.size()-1].addr == (a & 32'h0001FFFF) &&
          sbq[sbq.size()-1].f3 == f3 && !(sbq.size() == 1 && !mem_busy)) merge = 1'b1;
`endif
      if (merge) begin
        sbq[sbq.size()-1].data = d;
      end else begin
        e.addr = a & 32'h0001FFFF; e.data = d; e.f3 = f3;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  task automatic check_load(input string name, input logic lv, input logic [31:0] a, input logic [2:0] f3,
                            input logic e_hit, input logic e_stall, input logic [31:0] e_data);
    @(negedge clk);
    ld_valid = lv; ld_addr = a; ld_funct3 = f3;
    #1;
    total++;
    if (fwd_hit !== e_hit || ld_stall !== e_stall || fwd_data !== e_data) begin
      bad++;
      $display("[TB] FAIL %s: got hit=%b stall=%b data=%h, want hit=%b stall=%b data=%h",
               name, fwd_hit, ld_stall, fwd_data, e_hit, e_stall, e_data);
    end
    ld_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      #3;
      if (sb_empty && sbq.size() == 0) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got sb_empty=%b pending=%0d, want empty", name, sb_empty, sbq.size());
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (mem_we !== 1'b0 || sb_empty !== 1'b1 || st_ready !== 1'b1 || fwd_hit !== 1'b0 ||
        ld_stall !== 1'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0 || mem_funct3 !== 3'b000 || fwd_data !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_state: got we=%b empty=%b rdy=%b hit=%b stall=%b addr=%h wd=%h, want 0 1 1 0 0 0 0",
               mem_we, sb_empty, st_ready, fwd_hit, ld_stall, mem_addr, mem_wd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_drain();
    mem_busy = 1'b0;
    do_store(32'h100, 32'hDEADBEEF, 3'b010);
    @(negedge clk);
    #1;
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wd !== 32'hDEADBEEF || mem_funct3 !== 3'b010) begin
      bad++;
      $display("[TB] FAIL store_drain: got we=%b addr=%h wd=%h f3=%b, want 1 00000100 deadbeef 010",
               mem_we, mem_addr, mem_wd, mem_funct3);
    end
    @(negedge clk);
    #1;
    total++;
    if (sb_empty !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain_empty: got empty=%b we=%b, want 1 0", sb_empty, mem_we);
    end
  endtask

  task automatic test_fill();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) do_store(32'h200 + i, 32'hA0 + i, 3'b000);
    @(negedge clk);
    #1;
    total++;
    if (st_ready !== 1'b0 || mem_we !== 1'b0 || sb_empty !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fill_full: got rdy=%b we=%b empty=%b, want 0 0 0", st_ready, mem_we, sb_empty);
    end
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h200 + i) begin
        bad++;
        $display("[TB] FAIL fill_drain%0d: got we=%b addr=%h, want 1 %h", i, mem_we, mem_addr, 32'h200 + i);
      end
      if (i == 1) begin
        total++;
        if (st_ready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL fill_ready: got %b, want 1", st_ready);
        end
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (sb_empty !== 1'b1 || st_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fill_empty: got empty=%b rdy=%b, want 1 1", sb_empty, st_ready);
    end
  endtask

  task automatic test_forward();
    mem_busy = 1'b1;
    do_store(32'h20, 32'h12345680, 3'b000);
    check_load("fwd_lb",      1'b1, 32'h20, 3'b000, 1'b1, 1'b0, 32'hFFFFFF80);
    check_load("fwd_lbu",     1'b1, 32'h20, 3'b100, 1'b1, 1'b0, 32'h00000080);
    check_load("fwd_lh_size", 1'b1, 32'h20, 3'b001, 1'b0, 1'b1, 32'h0);
    check_load("fwd_lw_miss", 1'b1, 32'h1C, 3'b010, 1'b0, 1'b0, 32'h0);
    check_load("fwd_lw_part", 1'b1, 32'h1E, 3'b010, 1'b0, 1'b1, 32'h0);
    check_load("fwd_bad_f3",  1'b1, 32'h20, 3'b011, 1'b0, 1'b0, 32'h0);
    check_load("fwd_novalid", 1'b0, 32'h20, 3'b000, 1'b0, 1'b0, 32'h0);
    mem_busy = 1'b0;
    wait_empty("forward");
  endtask

  task automatic test_partial();
    mem_busy = 1'b1;
    do_store(32'h40, 32'hCAFEF00D, 3'b010);
    check_load("partial_stall", 1'b1, 32'h42, 3'b001, 1'b0, 1'b1, 32'h0);
    check_load("partial_lhu",   1'b1, 32'h40, 3'b101, 1'b0, 1'b1, 32'h0);
    mem_busy = 1'b0;
    wait_empty("partial");
    check_load("partial_after", 1'b1, 32'h42, 3'b001, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    mem_busy = 1'b1;
    do_store(32'h1FFFE, 32'h11111111, 3'b010);
    do_store(32'h1FFFE, 32'h22222222, 3'b010);
    check_load("wrap_young",  1'b1, 32'h1FFFE, 3'b010, 1'b1, 1'b0, 32'h22222222);
    check_load("wrap_lb1",    1'b1, 32'h00001, 3'b000, 1'b0, 1'b1, 32'h0);
    check_load("wrap_lh",     1'b1, 32'h1FFFF, 3'b001, 1'b0, 1'b1, 32'h0);
    check_load("wrap_lb2",    1'b1, 32'h00002, 3'b000, 1'b0, 1'b0, 32'h0);
    mem_busy = 1'b0;
    wait_empty("wrap");
  endtask

  task automatic test_back_to_back();
    mem_busy = 1'b0;
    do_store(32'h300, 32'h00000300, 3'b010);
    do_store(32'h304, 32'h00000304, 3'b010);
    do_store(32'h308, 32'h00000308, 3'b001);
    do_store(32'h30C, 32'h0000030C, 3'b011);
    @(negedge clk);
    #1;
    total++;
    if (sb_empty !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_empty: got empty=%b we=%b, want 1 0", sb_empty, mem_we);
    end
  endtask

  task automatic test_async_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) do_store(32'h400 + 4 * i, 32'h55550000 + i, 3'b010);
    @(negedge clk);
    mem_busy = 1'b0;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    total++;
    if (mem_we !== 1'b0 || sb_empty !== 1'b1 || st_ready !== 1'b1 || mem_addr !== 32'h0) begin
      bad++;
      $display("[TB] FAIL areset_now: got we=%b empty=%b rdy=%b addr=%h, want 0 1 1 0",
               mem_we, sb_empty, st_ready, mem_addr);
    end
    @(posedge clk);
    #1;
    total++;
    if (mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL areset_edge: got we=%b, want 0", mem_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (sb_empty !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL areset_release: got empty=%b we=%b, want 1 0", sb_empty, mem_we);
    end
  endtask

  initial begin
    test_reset();
    test_store_drain();
    test_fill();
    test_forward();
    test_partial();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO store buffer between the memory-stage issue logic and data-memory write port 1.
- Accepts committed stores (SB/SH/SW) and drains them in order into the data memory's WE1/A1/WD1/AddressingControl1 inputs whenever that port is not claimed by a load.
- Provides store-to-load forwarding and a stall signal for partially overlapping loads, so loads never read stale memory.

Parameters:
- XLEN, 32, data/address width of store and load ports
- ADDRESS_WIDTH, 17, byte-address bits used for compare and drain (matches data memory)
- DEPTH, 4, number of buffer entries; power of two, minimum 2

Ports:
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- st_valid  input  1  store request valid
- st_ready  output  1  buffer can accept a store this cycle
- st_addr  input  XLEN  store byte address
- st_data  input  XLEN  store data, low bytes significant
- st_funct3  input  3  000 SB, 001 SH, 010 SW
- mem_busy  input  1  write port 1 is in use by a load this cycle; drain inhibited
- mem_we  output  1  write enable to data memory
- mem_addr  output  XLEN  drain address, zero-extended from ADDRESS_WIDTH
- mem_wd  output  XLEN  drain data
- mem_funct3  output  3  drain store type
- ld_valid  input  1  load lookup valid
- ld_addr  input  XLEN  load byte address
- ld_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- fwd_hit  output  1  load fully served from buffer
- fwd_data  output  XLEN  forwarded, extended load data
- ld_stall  output  1  load overlaps a buffered store that cannot be forwarded
- sb_empty  output  1  no valid entries, used by FENCE and ECALL

Behaviour:
- Storage:
  - Circular array of DEPTH entries, each holding {addr[ADDRESS_WIDTH-1:0], data, funct3}.
  - head and tail pointers are $clog2(DEPTH) bits; count is $clog2(DEPTH)+1 bits.
- Reset (async, rst_n=0):
  - head=tail=count=0.
  - mem_we=0, fwd_hit=0, ld_stall=0, sb_empty=1, st_ready=1.
  - mem_addr, mem_wd, mem_funct3, fwd_data = 0.
- Enqueue: on the edge where st_valid && st_ready, write the entry at tail, then tail++ (wraps at DEPTH) and count++.
  - st_ready = (count < DEPTH). Ready does not depend on a same-cycle drain.
  - st_funct3 not in {000,001,010}: the handshake completes but no entry is allocated.
- Drain (combinational outputs, registered pointer update):
  - mem_we = (count != 0) && !mem_busy && rst_n.
  - mem_addr, mem_wd, mem_funct3 come from the head entry. They are 0 when count == 0.
  - On an edge with mem_we=1: head++ (wraps), count--. The data memory samples the same edge.
  - Latency: a store enqueued at edge N is written at edge N+1 at the earliest, if the buffer was empty and mem_busy=0.
- Simultaneous enqueue and drain: count is unchanged; head and tail both advance.
- Forwarding lookup (combinational, evaluated only when ld_valid=1; otherwise all lookup outputs are 0):
  - Byte sets: store bytes are (addr+i) mod 2^ADDRESS_WIDTH for i < size (1/2/4); load bytes likewise.
  - Overlap means any byte is shared. Compare wraps exactly as the memory does.
  - Select the youngest valid entry that overlaps.
  - If its addr == ld_addr and its size == load size: fwd_hit=1, fwd_data = store data sign- or zero-extended per ld_funct3.
  - Otherwise: ld_stall=1, fwd_hit=0.
  - No overlap: fwd_hit=0, ld_stall=0, fwd_data=0.
  - Invalid ld_funct3: all lookup outputs are 0.
- An entry being drained this cycle still participates in lookup this cycle.
- sb_empty = (count == 0).
- Reset mid-drain: the in-flight entry is dropped with no write, because mem_we is forced to 0 while rst_n=0.

Optional Feature:
- STORE_MERGE_EN defined: a valid store with addr and funct3 equal to the youngest entry overwrites that entry's data. No allocation occurs and count is unchanged.
  - Applies only if that entry is not the head being drained this cycle.
  - st_ready is still required.
- STORE_MERGE_EN not defined: every valid store allocates a new entry.

Test Plan:
- Store then drain: reset, SW addr=0x100, data=0xDEADBEEF, mem_busy=0 -> next cycle mem_we=1, mem_addr=0x100, mem_wd=0xDEADBEEF, mem_funct3=010; following cycle sb_empty=1.
- Fill and stall: mem_busy=1, enqueue 4 SB stores -> st_ready=0 after the 4th. Release mem_busy -> 4 drains in FIFO order on consecutive cycles, st_ready=1 after the first.
- Forward with sign extension: SB 0x80 to addr 0x20, then LB at 0x20 -> fwd_hit=1, fwd_data=0xFFFFFF80. LBU at 0x20 -> fwd_data=0x00000080.
- Partial overlap: SW to 0x40 buffered, then LH at 0x42 -> ld_stall=1, fwd_hit=0. After drain, same LH -> ld_stall=0, fwd_hit=0.
- Youngest wins with wrap: SW 0x11111111 then SW 0x22222222 to 0x1FFFE (wraps to 0x00001), then LW 0x1FFFE -> fwd_hit=1, fwd_data=0x22222222. With STORE_MERGE_EN, count=1 after both stores.
- Async reset with count=3 -> mem_we=0 and sb_empty=1 immediately; no write on the next edge.
